// File: rtl/addsub_pkg.sv
// addsub_pkg: mode constants and FSM state encoding shared by the serial adder/subtractor
package addsub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/addsub_digit_adder.sv
// digit_adder: DIGIT-wide combinational ripple of full adders, exposing the carry into its MSB
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement add/sub with start/done handshake; ADDSUB_SATURATE_EN enables overflow clamping
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d, res, fin;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [DIGIT-1:0] sum;
  logic             sl_cout, c_msb, last;
  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .cin      (carry_q),
    .sum      (sum),
    .cout     (sl_cout),
    .c_msb_in (c_msb)
  );
  assign last = cnt_q == CW'(N - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    ready = state_q == IDLE;
    done  = state_q == DONE;
  end
  always_comb begin
    res = WIDTH'({sum, acc_q} >> DIGIT);
`ifdef ADDSUB_SATURATE_EN
    fin = (c_msb ^ sl_cout) ? {a_q[DIGIT-1], {(WIDTH-1){~a_q[DIGIT-1]}}} : res;
`else
    fin = res;
`endif
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (state_q == IDLE && start) begin
      a_d     = a;
      b_d     = mode == MODE_SUB ? ~b : b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      acc_d   = res;
      carry_d = sl_cout;
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        s_d    = fin;
        cout_d = sl_cout;
        ovf_d  = c_msb ^ sl_cout;
        zero_d = fin == '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: vector table, corner sequences and random sweep over DIGIT = 1,2,4,8 against an arithmetic model
module tb_addsub_serial;
`ifdef ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n, start, mode, cin;
  logic [7:0] a, b;
  logic       ready_v [4];
  logic       done_v [4];
  logic [7:0] s_v [4];
  logic       cout_v [4];
  logic       ovf_v [4];
  logic       zero_v [4];
  int         checks = 0;
  int         errors = 0;
  int         lat [4];
  int         npulse [4];
  int         unstable [4];
  logic       rdy1 [4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    addsub_serial #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .cin   (cin),
      .a     (a),
      .b     (b),
      .ready (ready_v[g]),
      .done  (done_v[g]),
      .s     (s_v[g]),
      .cout  (cout_v[g]),
      .ovf   (ovf_v[g]),
      .zero  (zero_v[g])
    );
  end
  typedef struct {
    logic       m, ci;
    logic [7:0] x, y, es;
    logic       ec, eo, ez;
  } vec_t;
  vec_t tbl [8];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  function automatic void model(input logic m, input logic ci, input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] rs, output logic rc, output logic ro, output logic rz);
    logic [7:0] yb;
    logic [8:0] t;
    yb = m ? ~y : y;
    t  = {1'b0, x} + {1'b0, yb} + 9'(ci);
    rc = t[8];
    ro = (x[7] == yb[7]) && (t[7] != x[7]);
    rs = (SAT && ro) ? (x[7] ? 8'h80 : 8'h7F) : t[7:0];
    rz = rs == 8'h00;
  endfunction
  task automatic run_op(input logic m, input logic ci, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] s_prev [4];
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0; npulse[i] = 0; unstable[i] = 0; s_prev[i] = s_v[i];
    end
    mode = m; cin = ci; a = x; b = y; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom); cin = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
        if (k == 1) rdy1[i] = ready_v[i];
        if (k <= (8 >> i) && s_v[i] !== s_prev[i]) unstable[i]++;
        if (done_v[i]) begin
          npulse[i]++;
          if (lat[i] == 0) lat[i] = k;
        end
      end
    end
  endtask
  task automatic check_op(input string nm, input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s d%0d s", nm, 1 << i), 32'(s_v[i]), 32'(es));
      chk($sformatf("%s d%0d cout", nm, 1 << i), 32'(cout_v[i]), 32'(ec));
      chk($sformatf("%s d%0d ovf", nm, 1 << i), 32'(ovf_v[i]), 32'(eo));
      chk($sformatf("%s d%0d zero", nm, 1 << i), 32'(zero_v[i]), 32'(ez));
      chk($sformatf("%s d%0d latency", nm, 1 << i), 32'(lat[i]), 32'((8 >> i) + 1));
      chk($sformatf("%s d%0d done_pulses", nm, 1 << i), 32'(npulse[i]), 32'd1);
      chk($sformatf("%s d%0d ready_drop", nm, 1 << i), 32'(rdy1[i]), 32'd0);
      chk($sformatf("%s d%0d s_stable", nm, 1 << i), 32'(unstable[i]), 32'd0);
    end
  endtask
  task automatic model_op(input string nm, input logic m, input logic ci, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] rs;
    logic       rc, ro, rz;
    model(m, ci, x, y, rs, rc, ro, rz);
    run_op(m, ci, x, y);
    check_op(nm, rs, rc, ro, rz);
  endtask
  initial begin
    logic [7:0] x2, y2, rs;
    logic       m2, c2, rc, ro, rz;
    int         dcount;
    tbl[0] = '{1'b0, 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h7F, 8'h01, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h80, 8'h01, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 8'h80, 8'h80, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1, !SAT};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset d%0d ready", 1 << i), 32'(ready_v[i]), 32'd1);
      chk($sformatf("reset d%0d done", 1 << i), 32'(done_v[i]), 32'd0);
      chk($sformatf("reset d%0d s", 1 << i), 32'(s_v[i]), 32'd0);
      chk($sformatf("reset d%0d flags", 1 << i), 32'({cout_v[i], ovf_v[i], zero_v[i]}), 32'd0);
    end
    rst_n = 1'b1;
    tick;
    for (int v = 0; v < 8; v++) begin
      run_op(tbl[v].m, tbl[v].ci, tbl[v].x, tbl[v].y);
      check_op($sformatf("vec%0d", v), tbl[v].es, tbl[v].ec, tbl[v].eo, tbl[v].ez);
    end
    // start held high with changing operands: only one op, re-accept right after DONE
    mode = 1'b0; cin = 1'b0; a = 8'h11; b = 8'h22; start = 1'b1;
    dcount = 0; x2 = 8'h00; y2 = 8'h00; m2 = 1'b0; c2 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick;
      if (done_v[1] && k <= 6) dcount++;
      if (k == 5) chk("hold s", 32'(s_v[1]), 32'h33);
      if (k == 6) chk("hold ready_after_done", 32'(ready_v[1]), 32'd1);
      if (k == 7) chk("hold reaccept", 32'(ready_v[1]), 32'd0);
      if (k == 11) begin
        model(m2, c2, x2, y2, rs, rc, ro, rz);
        chk("hold second_done", 32'(done_v[1]), 32'd1);
        chk("hold second_s", 32'(s_v[1]), 32'(rs));
        chk("hold second_cout", 32'(cout_v[1]), 32'(rc));
      end
      a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom); cin = 1'($urandom);
      if (k == 6) begin x2 = a; y2 = b; m2 = mode; c2 = cin; end
      if (k == 7) start = 1'b0;
    end
    chk("hold done_pulses", 32'(dcount), 32'd1);
    for (int k = 0; k < 10; k++) tick;
    for (int i = 0; i < 4; i++) chk($sformatf("hold d%0d idle", 1 << i), 32'(ready_v[i]), 32'd1);
    // reset in the middle of RUN discards the partial result
    model_op("pre_reset", 1'b0, 1'b0, 8'h12, 8'h34);
    mode = 1'b0; cin = 1'b1; a = 8'h0F; b = 8'h70; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midreset d%0d ready", 1 << i), 32'(ready_v[i]), 32'd1);
      chk($sformatf("midreset d%0d done", 1 << i), 32'(done_v[i]), 32'd0);
      chk($sformatf("midreset d%0d s", 1 << i), 32'(s_v[i]), 32'd0);
      chk($sformatf("midreset d%0d flags", 1 << i), 32'({cout_v[i], ovf_v[i], zero_v[i]}), 32'd0);
    end
    model_op("post_reset", 1'b1, 1'b1, 8'h40, 8'hC1);
    for (int n = 0; n < 3000; n++)
      model_op($sformatf("rand%0d", n), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
